// File: rtl/wts_mixer_pkg.sv
// rtl/wts_mixer_pkg.sv - shared types, widths and helpers for the channel mixer
//
// Purpose : state encoding, datapath widths and the envelope clamp helper
//           used by wts_mixer_term and wts_channel_mixer.
// Ports   : none (package).
package wts_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } mix_state_t;

    localparam int WAVE_W = 8;
    localparam int ENV_W  = 8;
    localparam int VOL_W  = 4;
    localparam int SEL_W  = 3;
    localparam int TERM_W = 19;
    localparam int ACC_W  = 22;
    localparam int OUT_W  = 16;

    localparam logic [ENV_W-1:0] ENV_MAX = 8'd128;

    // Envelope levels above full scale are treated as full scale.
    function automatic logic [ENV_W-1:0] clamp_env(input logic [ENV_W-1:0] env);
        return (env > ENV_MAX) ? ENV_MAX : env;
    endfunction

endpackage

// File: rtl/wts_mixer_term.sv
// rtl/wts_mixer_term.sv - registered per-channel product stage of the mixer
//
// Purpose : computes enable ? wave * min(env,128) * vol : 0 for the channel
//           currently selected and registers it together with a valid flag.
// Ports   : clk, nreset        clock / asynchronous active-low reset
//           i_clear            start of frame: drop the product valid flag
//           i_load             capture the product of the current inputs
//           i_wave/i_env/i_vol/i_enable  channel inputs
//           o_prod, o_prod_valid         registered signed product and flag
module wts_mixer_term
    import wts_mixer_pkg::*;
(
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     i_clear,
    input  logic                     i_load,
    input  logic [WAVE_W-1:0]        i_wave,
    input  logic [ENV_W-1:0]         i_env,
    input  logic [VOL_W-1:0]         i_vol,
    input  logic                     i_enable,
    output logic signed [TERM_W-1:0] o_prod,
    output logic                     o_prod_valid
);

    logic [ENV_W-1:0]         w_env_c;
    logic signed [TERM_W-1:0] w_wave_x;
    logic signed [TERM_W-1:0] w_env_x;
    logic signed [TERM_W-1:0] w_vol_x;
    logic signed [TERM_W-1:0] w_term;

    logic signed [TERM_W-1:0] r_prod;
    logic                     r_prod_valid;

    assign w_env_c  = clamp_env(i_env);

    // Wave is sign-extended, envelope and volume are zero-extended, so the
    // whole product is a signed multiply that fits in TERM_W bits.
    assign w_wave_x = TERM_W'($signed(i_wave));
    assign w_env_x  = $signed(TERM_W'(w_env_c));
    assign w_vol_x  = $signed(TERM_W'(i_vol));
    assign w_term   = i_enable ? (w_wave_x * w_env_x * w_vol_x) : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
        end else if (i_clear) begin
            r_prod_valid <= 1'b0;
        end else if (i_load) begin
            r_prod       <= w_term;
            r_prod_valid <= 1'b1;
        end
    end

    assign o_prod       = r_prod;
    assign o_prod_valid = r_prod_valid;

endmodule

// File: rtl/wts_channel_mixer.sv
// rtl/wts_channel_mixer.sv - time-multiplexed channel mixer top level
//
// Purpose : once per requested frame scans CH_NUM channels, accumulates
//           wave * envelope * volume products and outputs a 16-bit sample.
//           Optional feature macro: WTS_MIXER_SATURATION_EN (>>>4 with clamp
//           instead of >>>6).
// Ports   : clk, nreset          clock / asynchronous active-low reset
//           active               timing pulse qualifying every state change
//           sample_start         frame request
//           ch_sel               channel index presented to upstream
//           ch_wave/ch_envelope/ch_volume/ch_enable  selected channel data
//           mix_out, mix_valid   mixed sample and its one-period strobe
//           busy                 frame in progress
module wts_channel_mixer
    import wts_mixer_pkg::*;
#(
    parameter int CH_NUM = 6
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              active,
    input  logic              sample_start,
    output logic [SEL_W-1:0]  ch_sel,
    input  logic [WAVE_W-1:0] ch_wave,
    input  logic [ENV_W-1:0]  ch_envelope,
    input  logic [VOL_W-1:0]  ch_volume,
    input  logic              ch_enable,
    output logic [OUT_W-1:0]  mix_out,
    output logic              mix_valid,
    output logic              busy
);

    mix_state_t               r_state;
    mix_state_t               w_state_nxt;
    logic [SEL_W-1:0]         r_ch_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]         r_mix_out;
    logic                     r_mix_valid;

    logic                     w_clear;
    logic                     w_load;
    logic                     w_flush;
    logic                     w_out;
    logic                     w_last;
    logic signed [TERM_W-1:0] w_prod;
    logic                     w_prod_valid;
    logic signed [ACC_W-1:0]  w_acc_sh;
    logic [OUT_W-1:0]         w_scaled;

    assign w_last = (r_ch_cnt == SEL_W'(CH_NUM - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The OUT period also accepts a new request so frames can run back to
    // back with a period of CH_NUM+2 active cycles; the old sum is scaled
    // out on the same edge that clears the accumulator.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_out       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (active && sample_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_load = active;
                if (active && w_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_flush = active;
                if (active) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out = active;
                if (active) begin
                    if (sample_start) begin
                        w_clear     = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    wts_mixer_term u_term (
        .clk          (clk),
        .nreset       (nreset),
        .i_clear      (w_clear),
        .i_load       (w_load),
        .i_wave       (ch_wave),
        .i_env        (ch_envelope),
        .i_vol        (ch_volume),
        .i_enable     (ch_enable),
        .o_prod       (w_prod),
        .o_prod_valid (w_prod_valid)
    );

`ifdef WTS_MIXER_SATURATION_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = 22'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -22'sd32768;

    assign w_acc_sh = r_acc >>> 4;

    always_comb begin
        w_scaled = OUT_W'(w_acc_sh);
        if (w_acc_sh > SAT_HI) begin
            w_scaled = 16'h7fff;
        end else if (w_acc_sh < SAT_LO) begin
            w_scaled = 16'h8000;
        end
    end
`else
    // |acc| <= 8 * 245760, so acc >>> 6 always fits in 16 bits.
    assign w_acc_sh = r_acc >>> 6;
    assign w_scaled = OUT_W'(w_acc_sh);
`endif

    // The product register lags the channel counter by one cycle, so each
    // SCAN step adds the previous channel and FLUSH adds the last one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc       <= '0;
            r_ch_cnt    <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
        end else begin
            if (w_clear) begin
                r_acc    <= '0;
                r_ch_cnt <= '0;
            end else if (w_load) begin
                if (w_prod_valid) begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                end
                r_ch_cnt <= r_ch_cnt + SEL_W'(1);
            end else if (w_flush) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (w_out) begin
                r_mix_out <= w_scaled;
            end
            if (active) begin
                r_mix_valid <= w_out;
            end
        end
    end

    assign ch_sel    = (r_state == ST_SCAN) ? r_ch_cnt : '0;
    assign busy      = (r_state != ST_IDLE);
    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// tb/tb_wts_channel_mixer.sv - self-checking bench for wts_channel_mixer
module tb_wts_channel_mixer;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        active = 1'b0;
    logic        sample_start = 1'b0;
    logic [2:0]  ch_sel;
    logic [7:0]  ch_wave;
    logic [7:0]  ch_envelope;
    logic [3:0]  ch_volume;
    logic        ch_enable;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;

    int t_wave[8];
    int t_env[8];
    int t_vol[8];
    int t_en[8];

    int checks = 0;
    int errors = 0;
    int div = 0;

    wts_channel_mixer #(.CH_NUM(N)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .active       (active),
        .sample_start (sample_start),
        .ch_sel       (ch_sel),
        .ch_wave      (ch_wave),
        .ch_envelope  (ch_envelope),
        .ch_volume    (ch_volume),
        .ch_enable    (ch_enable),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div    = (div == 2) ? 0 : div + 1;
        active = (div == 0);
    end

    assign ch_wave     = 8'(t_wave[ch_sel]);
    assign ch_envelope = 8'(t_env[ch_sel]);
    assign ch_volume   = 4'(t_vol[ch_sel]);
    assign ch_enable   = t_en[ch_sel] != 0;

    typedef struct {
        int ch;
        bit all;
        int wave;
        int env;
        int vol;
        int exp_def;
        int exp_sat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic act_edge();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!active && n < 20);
        if (!active) begin
            checks++;
            errors++;
            $display("FAIL active_timeout actual 0 expected 1");
        end
        #1;
    endtask

    function automatic int model_term(int w8, int env, int vol, int en);
        int sw = (w8 > 127) ? w8 - 256 : w8;
        int e  = (env > 128) ? 128 : env;
        return (en != 0) ? sw * e * vol : 0;
    endfunction

    function automatic int floor_div(int a, int b);
        int q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_mix();
        int sum = 0;
        int q;
        for (int c = 0; c < N; c++) sum += model_term(t_wave[c], t_env[c], t_vol[c], t_en[c]);
`ifdef WTS_MIXER_SATURATION_EN
        q = floor_div(sum, 16);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`else
        q = floor_div(sum, 64);
`endif
        return q;
    endfunction

    function automatic int vexp(vec_t v);
`ifdef WTS_MIXER_SATURATION_EN
        return v.exp_sat;
`else
        return v.exp_def;
`endif
    endfunction

    task automatic load_vec(input vec_t v);
        for (int c = 0; c < 8; c++) begin
            if (c < N && (v.all || c == v.ch)) begin
                t_wave[c] = v.wave & 255;
                t_env[c]  = v.env;
                t_vol[c]  = v.vol;
                t_en[c]   = 1;
            end else begin
                t_wave[c] = int'($urandom_range(0, 255));
                t_env[c]  = int'($urandom_range(0, 255));
                t_vol[c]  = int'($urandom_range(0, 15));
                t_en[c]   = 0;
            end
        end
    endtask

    task automatic run_frame(input string nm, input int exp, input int mid_k);
        sample_start = 1'b1;
        act_edge();
        sample_start = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            if (k <= N) chk({nm, "_ch_sel"}, int'(ch_sel), k - 1);
            chk({nm, "_busy"}, int'(busy), 1);
            if (k == mid_k) sample_start = 1'b1;
            act_edge();
            sample_start = 1'b0;
            chk({nm, "_valid"}, int'(mix_valid), (k == N + 2) ? 1 : 0);
        end
        chk({nm, "_mix_out"}, int'($signed(mix_out)), exp);
        chk({nm, "_busy_done"}, int'(busy), 0);
        act_edge();
        chk({nm, "_valid_clear"}, int'(mix_valid), 0);
        chk({nm, "_hold"}, int'($signed(mix_out)), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ch: 0, all: 0, wave:  127, env: 128, vol: 15, exp_def:   3810, exp_sat:  15240};
        vecs[1] = '{ch: 0, all: 1, wave: -128, env: 128, vol: 15, exp_def: -23040, exp_sat: -32768};
        vecs[2] = '{ch: 2, all: 0, wave:   10, env: 200, vol:  1, exp_def:     20, exp_sat:     80};
        vecs[3] = '{ch: 0, all: 1, wave:   -1, env:   1, vol:  1, exp_def:     -1, exp_sat:     -1};
        vecs[4] = '{ch: 5, all: 0, wave: -128, env: 128, vol: 15, exp_def:  -3840, exp_sat: -15360};
        vecs[5] = '{ch: 0, all: 1, wave:  127, env: 255, vol: 15, exp_def:  22860, exp_sat:  32767};
        vecs[6] = '{ch: 3, all: 0, wave:    1, env:   0, vol: 15, exp_def:      0, exp_sat:      0};
        vecs[7] = '{ch: 1, all: 0, wave:   -3, env:   5, vol:  7, exp_def:     -2, exp_sat:     -7};

        load_vec(vecs[0]);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mix_out", int'(mix_out), 0);
        chk("rst_valid", int'(mix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i]);
            run_frame($sformatf("vec%0d", i), vexp(vecs[i]), 0);
        end

        // request in the middle of a frame is ignored
        load_vec(vecs[0]);
        run_frame("midstart", vexp(vecs[0]), 3);
        repeat (10) begin
            act_edge();
            chk("midstart_no_extra", int'(mix_valid) + int'(busy), 0);
        end

        // reset in the middle of a frame
        load_vec(vecs[1]);
        sample_start = 1'b1;
        act_edge();
        sample_start = 1'b0;
        repeat (4) act_edge();
        nreset = 1'b0;
        #1;
        chk("midrst_mix_out", int'(mix_out), 0);
        chk("midrst_valid", int'(mix_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ch_sel", int'(ch_sel), 0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        load_vec(vecs[2]);
        run_frame("after_rst", vexp(vecs[2]), 0);

        // back-to-back frames
        load_vec(vecs[3]);
        sample_start = 1'b1;
        act_edge();
        sample_start = 1'b0;
        for (int k = 1; k <= 2 * (N + 2); k++) begin
            if (k == N + 2) sample_start = 1'b1;
            act_edge();
            sample_start = 1'b0;
            chk("b2b_valid", int'(mix_valid), (k == N + 2 || k == 2 * (N + 2)) ? 1 : 0);
            if (k == N + 2) begin
                chk("b2b_first", int'($signed(mix_out)), vexp(vecs[3]));
                load_vec(vecs[0]);
            end
        end
        chk("b2b_second", int'($signed(mix_out)), vexp(vecs[0]));
        act_edge();
        chk("b2b_busy_done", int'(busy), 0);

        // randomized frames against the reference model
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < N; c++) begin
                t_wave[c] = int'($urandom_range(0, 255));
                t_env[c]  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 128))
                                                        : int'($urandom_range(0, 255));
                t_vol[c]  = int'($urandom_range(0, 15));
                t_en[c]   = int'($urandom_range(0, 3) != 0);
            end
            run_frame($sformatf("rand%0d", r), model_mix(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
